// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single memory controller port.
// Optional BUSY watchdog enabled by defining MEMARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no owner, waiting for a request
// BUSY  | latched transaction driven toward the memory controller
// RESP  | one-cycle ready pulse to the owner
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] c0_a,
  input  logic [31:0] c0_d,
  input  logic        c0_we,
  input  logic        c0_rd,
  input  logic [31:0] c1_a,
  input  logic [31:0] c1_d,
  input  logic        c1_we,
  input  logic        c1_rd,
  output logic [31:0] c0_spo,
  output logic        c0_ready,
  output logic [31:0] c1_spo,
  output logic        c1_ready,
  output logic [31:0] mem_a,
  output logic [31:0] mem_d,
  output logic        mem_we,
  output logic        mem_rd,
  input  logic [31:0] mem_spo,
  input  logic        mem_ready,
  output logic [1:0]  grant,
  output logic        irq_timeout
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        owner_q, owner_d;
  logic [31:0] lat_a_q, lat_a_d;
  logic [31:0] lat_d_q, lat_d_d;
  logic        lat_we_q, lat_we_d;
  logic        lat_rd_q, lat_rd_d;
  logic [31:0] c0_spo_q, c0_spo_d;
  logic [31:0] c1_spo_q, c1_spo_d;
  logic        req0, req1;
  logic        win;
  logic        timeout_hit;

  assign req0 = c0_rd | c0_we;
  assign req1 = c1_rd | c1_we;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    lat_a_d      = lat_a_q;
    lat_d_d      = lat_d_q;
    lat_we_d     = lat_we_q;
    lat_rd_d     = lat_rd_q;
    c0_spo_d     = c0_spo_q;
    c1_spo_d     = c1_spo_q;
    win          = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On contention the port that did not win last time goes next.
          win          = req1 ? (req0 ? ~last_grant_q : 1'b1) : 1'b0;
          owner_d      = win;
          last_grant_d = win;
          lat_a_d      = win ? c1_a : c0_a;
          lat_d_d      = win ? c1_d : c0_d;
          lat_we_d     = win ? c1_we : c0_we;
          lat_rd_d     = win ? (c1_rd & ~c1_we) : (c0_rd & ~c0_we);
          state_d      = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          state_d = RESP;
          if (lat_rd_q) begin
            if (owner_q) c1_spo_d = mem_spo;
            else         c0_spo_d = mem_spo;
          end
        end else if (timeout_hit) begin
          state_d = RESP;
          if (owner_q) c1_spo_d = 32'hFFFF_FFFF;
          else         c0_spo_d = 32'hFFFF_FFFF;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      lat_a_q      <= '0;
      lat_d_q      <= '0;
      lat_we_q     <= 1'b0;
      lat_rd_q     <= 1'b0;
      c0_spo_q     <= '0;
      c1_spo_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      lat_a_q      <= lat_a_d;
      lat_d_q      <= lat_d_d;
      lat_we_q     <= lat_we_d;
      lat_rd_q     <= lat_rd_d;
      c0_spo_q     <= c0_spo_d;
      c1_spo_q     <= c1_spo_d;
    end
  end

`ifdef MEMARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             irq_q, irq_d;

  // Counter holds the number of BUSY cycles already completed.
  assign timeout_hit = (state_q == BUSY) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    irq_d = irq_q | (timeout_hit & ~mem_ready);
    if (state_q == IDLE && state_d == BUSY) cnt_d = '0;
    else if (state_q == BUSY)               cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      irq_q <= irq_d;
    end
  end

  assign irq_timeout = irq_q;
`else
  logic timeout_cfg_unused;

  assign timeout_cfg_unused = (TIMEOUT_CYCLES > 0);
  assign timeout_hit        = 1'b0;
  assign irq_timeout        = 1'b0;
`endif

  assign mem_a    = (state_q == BUSY) ? lat_a_q : '0;
  assign mem_d    = (state_q == BUSY) ? lat_d_q : '0;
  assign mem_we   = (state_q == BUSY) & lat_we_q;
  assign mem_rd   = (state_q == BUSY) & lat_rd_q;
  assign grant    = (state_q == IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
  assign c0_ready = (state_q == RESP) & ~owner_q;
  assign c1_ready = (state_q == RESP) & owner_q;
  assign c0_spo   = c0_spo_q;
  assign c1_spo   = c1_spo_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; the timeout scenario runs when MEMARB_TIMEOUT_EN is defined.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] c0_a, c0_d, c1_a, c1_d;
  logic        c0_we, c0_rd, c1_we, c1_rd;
  logic [31:0] c0_spo, c1_spo;
  logic        c0_ready, c1_ready;
  logic [31:0] mem_a, mem_d, mem_spo;
  logic        mem_we, mem_rd, mem_ready;
  logic [1:0]  grant;
  logic        irq_timeout;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .c0_a(c0_a), .c0_d(c0_d), .c0_we(c0_we), .c0_rd(c0_rd),
    .c1_a(c1_a), .c1_d(c1_d), .c1_we(c1_we), .c1_rd(c1_rd),
    .c0_spo(c0_spo), .c0_ready(c0_ready),
    .c1_spo(c1_spo), .c1_ready(c1_ready),
    .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_rd(mem_rd),
    .mem_spo(mem_spo), .mem_ready(mem_ready),
    .grant(grant), .irq_timeout(irq_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [1:0]  exp_g;
    logic [31:0] val;

    rst = 1'b0; mem_ready = 1'b0; mem_spo = '0;
    c0_a = '0; c0_d = '0; c0_we = 1'b0; c0_rd = 1'b0;
    c1_a = '0; c1_d = '0; c1_we = 1'b0; c1_rd = 1'b0;
    tick();
    tick();
    rst = 1'b1;

    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_c0_ready", {31'd0, c0_ready}, 32'd0);
    chk("rst_c1_ready", {31'd0, c1_ready}, 32'd0);
    chk("rst_c0_spo", c0_spo, 32'd0);
    chk("rst_c1_spo", c1_spo, 32'd0);
    chk("rst_irq", {31'd0, irq_timeout}, 32'd0);

    // Single read on port 0, memory answers in the third BUSY cycle
    c0_rd = 1'b1; c0_a = 32'h100;
    tick();
    chk("t1_grant", {30'd0, grant}, 32'd1);
    chk("t1_mem_a", mem_a, 32'h100);
    for (int i = 1; i <= 3; i++) begin
      chk("t1_mem_rd", {31'd0, mem_rd}, 32'd1);
      chk("t1_c0_ready_busy", {31'd0, c0_ready}, 32'd0);
      if (i == 3) begin
        mem_ready = 1'b1; mem_spo = 32'hDEADBEEF;
      end
      tick();
    end
    chk("t1_c0_ready", {31'd0, c0_ready}, 32'd1);
    chk("t1_mem_rd_drop", {31'd0, mem_rd}, 32'd0);
    chk("t1_c0_spo", c0_spo, 32'hDEADBEEF);
    c0_rd = 1'b0; mem_ready = 1'b0; mem_spo = '0;
    tick();
    chk("t1_c0_ready_once", {31'd0, c0_ready}, 32'd0);
    chk("t1_grant_idle", {30'd0, grant}, 32'd0);

    // Both ports requesting continuously; reset so port 0 wins first
    rst = 1'b0; c0_rd = 1'b1; c1_rd = 1'b1; c0_a = 32'h10; c1_a = 32'h20;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      chk("t2_grant", {30'd0, grant}, {30'd0, exp_g});
      chk("t2_mem_a", mem_a, (i % 2 == 0) ? 32'h10 : 32'h20);
      val = 32'hA0 + 32'(i);
      mem_ready = 1'b1; mem_spo = val;
      tick();
      mem_ready = 1'b0;
      chk("t2_c0_ready", {31'd0, c0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("t2_c1_ready", {31'd0, c1_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      chk("t2_grant_idle", {30'd0, grant}, 32'd0);
    end
    c0_rd = 1'b0; c1_rd = 1'b0;
    chk("t2_c0_spo", c0_spo, 32'hA2);
    chk("t2_c1_spo", c1_spo, 32'hA3);

    // Write wins over read when both strobes are set
    c1_we = 1'b1; c1_rd = 1'b1; c1_d = 32'h12345678; c1_a = 32'h200;
    tick();
    chk("t3_grant", {30'd0, grant}, 32'd2);
    chk("t3_mem_we", {31'd0, mem_we}, 32'd1);
    chk("t3_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("t3_mem_d", mem_d, 32'h12345678);
    chk("t3_mem_a", mem_a, 32'h200);
    mem_ready = 1'b1; mem_spo = 32'h55555555;
    tick();
    chk("t3_c1_ready", {31'd0, c1_ready}, 32'd1);
    chk("t3_c1_spo_kept", c1_spo, 32'hA3);
    c1_we = 1'b0; c1_rd = 1'b0; mem_ready = 1'b0;
    tick();

    // Stray mem_ready while idle
    mem_ready = 1'b1; mem_spo = 32'h77777777;
    tick();
    chk("t4_c0_ready", {31'd0, c0_ready}, 32'd0);
    chk("t4_c1_ready", {31'd0, c1_ready}, 32'd0);
    chk("t4_grant", {30'd0, grant}, 32'd0);
    mem_ready = 1'b0;
    tick();
    chk("t4_c0_ready_2", {31'd0, c0_ready}, 32'd0);
    chk("t4_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("t4_c0_spo", c0_spo, 32'hA2);

    // Mid-BUSY request change, then reset while BUSY
    c0_rd = 1'b1; c0_a = 32'h300;
    tick();
    chk("t5_mem_rd", {31'd0, mem_rd}, 32'd1);
    c0_a = 32'h999;
    tick();
    chk("t5_mem_a_latched", mem_a, 32'h300);
    rst = 1'b0; c0_rd = 1'b0;
    tick();
    chk("t5_mem_rd_rst", {31'd0, mem_rd}, 32'd0);
    chk("t5_grant_rst", {30'd0, grant}, 32'd0);
    chk("t5_c0_ready_rst", {31'd0, c0_ready}, 32'd0);
    chk("t5_c0_spo_rst", c0_spo, 32'd0);
    rst = 1'b1;
    tick();
    chk("t5_c0_ready_after", {31'd0, c0_ready}, 32'd0);
    chk("t5_grant_after", {30'd0, grant}, 32'd0);

    // Memory never answers
    c0_rd = 1'b1; c0_a = 32'h400;
    tick();
`ifdef MEMARB_TIMEOUT_EN
    for (int i = 1; i <= 8; i++) begin
      chk("t6_mem_rd", {31'd0, mem_rd}, 32'd1);
      chk("t6_c0_ready_busy", {31'd0, c0_ready}, 32'd0);
      chk("t6_irq_busy", {31'd0, irq_timeout}, 32'd0);
      tick();
    end
    chk("t6_c0_ready", {31'd0, c0_ready}, 32'd1);
    chk("t6_c0_spo", c0_spo, 32'hFFFFFFFF);
    chk("t6_irq", {31'd0, irq_timeout}, 32'd1);
    c0_rd = 1'b0;
    tick();
    tick();
    chk("t6_irq_sticky", {31'd0, irq_timeout}, 32'd1);
    chk("t6_c0_ready_once", {31'd0, c0_ready}, 32'd0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("t6_irq_rst", {31'd0, irq_timeout}, 32'd0);
`else
    for (int i = 1; i <= 20; i++) begin
      if (i % 5 == 0) begin
        chk("t6_mem_rd", {31'd0, mem_rd}, 32'd1);
        chk("t6_c0_ready_busy", {31'd0, c0_ready}, 32'd0);
        chk("t6_irq", {31'd0, irq_timeout}, 32'd0);
      end
      tick();
    end
    mem_ready = 1'b1; mem_spo = 32'h0BADF00D;
    tick();
    mem_ready = 1'b0; c0_rd = 1'b0;
    chk("t6_c0_ready", {31'd0, c0_ready}, 32'd1);
    chk("t6_c0_spo", c0_spo, 32'h0BADF00D);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning BUSY cycles without mem_ready before a transaction is aborted.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-low.
REQ-004 SHALL have ports c0_a / c1_a, input, 32, requester address.
REQ-005 SHALL have ports c0_d / c1_d, input, 32, requester write data.
REQ-006 SHALL have ports c0_we, c0_rd / c1_we, c1_rd, input, 1 each, requester strobes, held until cN_ready.
REQ-007 SHALL have ports c0_spo / c1_spo, output, 32, registered read data.
REQ-008 SHALL have ports c0_ready / c1_ready, output, 1, one-cycle completion pulse.
REQ-009 SHALL have ports mem_a and mem_d, output, 32, toward the memory controller.
REQ-010 SHALL have ports mem_we and mem_rd, output, 1, toward the memory controller.
REQ-011 SHALL have ports mem_spo (input, 32) and mem_ready (input, 1), from the memory controller.
REQ-012 SHALL have port grant, output, 2, one-hot current owner (01 = port 0, 10 = port 1, 00 = none).
REQ-013 SHALL have port irq_timeout, output, 1, sticky timeout flag.

Function
REQ-014 SHALL treat reqN = cN_rd | cN_we; if both strobes are set, write wins and mem_rd SHALL be 0.
REQ-015 SHALL implement states IDLE, BUSY and RESP.
REQ-016 IDLE: mem_we = mem_rd = 0 and grant = 00; on any reqN, SHALL latch the winner's a, d, we and rd and go to BUSY.
REQ-017 Arbitration SHALL be round-robin with a last_grant register: a single requester wins; if both request, the port not equal to last_grant wins; last_grant updates on each grant.
REQ-018 BUSY: mem_a, mem_d, mem_we and mem_rd SHALL be driven from the latched values, and grant SHALL be one-hot for the owner.
REQ-019 Latency SHALL be: strobe from the request sampled in IDLE at cycle t reaches mem at t+1.
REQ-020 BUSY with mem_ready = 1: SHALL capture mem_spo into the owner's cN_spo and go to RESP; mem strobes SHALL drop at that edge.
REQ-021 RESP: the owner's cN_ready = 1 for exactly one cycle, then SHALL go to IDLE.
REQ-022 The non-owner's ready SHALL stay 0, and its request SHALL stay pending without loss.
REQ-023 A requester SHALL deassert its strobes in the cycle after cN_ready; a strobe still high in IDLE is a new transaction.
REQ-024 cN_spo SHALL hold its value until the next read completion on that port; writes SHALL leave cN_spo unchanged.
REQ-025 mem_ready in IDLE or RESP SHALL be ignored.
REQ-026 A request changing mid-BUSY SHALL not affect the latched transaction.

Reset
REQ-027 rst = 0 at an edge SHALL force state IDLE, last_grant = port 1 (so port 0 wins first), grant = 00, all strobes and ready = 0, cN_spo = 0, irq_timeout = 0, and timeout counter = 0.
REQ-028 Reset mid-BUSY SHALL abort the transaction with no ready pulse; mem strobes SHALL be 0 in the first cycle after the reset edge.

Configuration
REQ-029 With MEMARB_TIMEOUT_EN defined: a counter SHALL clear on entering BUSY and increment each BUSY cycle.
REQ-030 With MEMARB_TIMEOUT_EN defined: on reaching TIMEOUT_CYCLES without mem_ready, it SHALL go to RESP with owner cN_spo = 32'hFFFFFFFF.
REQ-031 With MEMARB_TIMEOUT_EN defined: on that timeout irq_timeout SHALL be set, staying 1 until reset.
REQ-032 Without MEMARB_TIMEOUT_EN: there SHALL be no counter, BUSY waits indefinitely, and irq_timeout SHALL be tied 0.

Verification
REQ-033 Bench SHALL cover: after reset, c0_rd with a = 0x100 and mem_ready after 3 BUSY cycles with mem_spo = 0xDEADBEEF -> mem_rd high 3 cycles, c0_ready pulse one cycle later, c0_spo = 0xDEADBEEF.
REQ-034 Bench SHALL cover: c0_rd and c1_rd in the same cycle, each re-requested after completion -> grants 01, 10, 01, 10, with no starvation.
REQ-035 Bench SHALL cover: c1_we and c1_rd both high with d = 0x12345678 -> mem_we = 1, mem_rd = 0, mem_d = 0x12345678, c1_spo unchanged.
REQ-036 Bench SHALL cover: mem_ready pulsed while IDLE -> no ready pulse and no state change.
REQ-037 Bench SHALL cover: rst = 0 during BUSY -> next cycle mem_rd = 0, grant = 00, no cN_ready pulse.
REQ-038 Bench SHALL cover, with MEMARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, mem_ready held 0 -> after 8 BUSY cycles c0_ready pulses with c0_spo = 0xFFFFFFFF, and irq_timeout = 1 until reset.
